// File: rtl/muldiv_scheduler.sv
// HI/LO owner for the MIPS core: launches fixed-latency mult/div operations,
// holds busy for the programmed cycle count, then commits the result to HI/LO.
module muldiv_scheduler #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_next;
  logic [3:0]  cnt;
  logic [31:0] hi_q, lo_q, hi_n, lo_n;
  logic        wr_pend;
  logic        is_mul, is_div, is_sgn, launch, done;

  // Sign-extend (or zero-extend) both operands to 64 bits so the truncated
  // product is the exact 64-bit result for either signedness.
  function automatic logic [63:0] mul_res(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
    logic signed [63:0] ea, eb;
    ea = {{32{sgn & a[31]}}, a};
    eb = {{32{sgn & b[31]}}, b};
    return ea * eb;
  endfunction

  // Divide on magnitudes and fix signs afterwards; this keeps the
  // 0x80000000 / -1 case well defined (quotient wraps to 0x80000000).
  function automatic logic [63:0] div_res(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
    logic        na, nb;
    logic [31:0] ua, ub, uq, ur;
    na = sgn & a[31];
    nb = sgn & b[31];
    ua = na ? (~a + 32'd1) : a;
    ub = nb ? (~b + 32'd1) : b;
    uq = ua / ub;
    ur = ua % ub;
    return {(na ? (~ur + 32'd1) : ur), ((na ^ nb) ? (~uq + 32'd1) : uq)};
  endfunction

  always_comb begin
    is_mul = (md_op == OP_MULT) || (md_op == OP_MULTU);
    is_div = (md_op == OP_DIV)  || (md_op == OP_DIVU);
    is_sgn = (md_op == OP_MULT) || (md_op == OP_DIV);
    launch = start && (state == IDLE) && (is_mul || is_div);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (launch)    state_next = RUN;
      RUN:     if (cnt == 4'd1) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == RUN) && (cnt == 4'd1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= 4'd0;
      wr_pend <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      if (launch) begin
        cnt     <= is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
        wr_pend <= !(is_div && (B == 32'd0));
      end else if (state == RUN) begin
        cnt <= cnt - 4'd1;
      end
      if (done && wr_pend) begin
        hi_q <= hi_n;
        lo_q <= lo_n;
      end else if (start && (state == IDLE)) begin
        if (md_op == OP_MTHI) hi_q <= A;
        if (md_op == OP_MTLO) lo_q <= A;
      end
    end
  end

  // Result is computed at launch and parked until the counter expires.
  always_ff @(posedge clk) begin
    if (launch) begin
      if (is_div) {hi_n, lo_n} <= (B == 32'd0) ? {hi_n, lo_n} : div_res(A, B, is_sgn);
      else        {hi_n, lo_n} <= mul_res(A, B, is_sgn);
    end
  end

  assign HI = hi_q;
  assign LO = lo_q;

endmodule

// File: tb/tb_muldiv_scheduler.sv
// Self-checking bench for muldiv_scheduler: directed cases plus randomized
// commands checked against an arithmetic reference of HI/LO and busy length.
module tb_muldiv_scheduler;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] m_hi, m_lo;

  muldiv_scheduler #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .A(a), .B(b), .busy(busy), .HI(hi), .LO(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // noise: 0 none, 1 random ignored commands while busy, 2 mtlo at cycle 3 and mult at cycle 4
  task automatic do_cmd(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                        input int noise);
    int          n;
    logic [31:0] eh, el;
    longint      sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up;
    eh = m_hi; el = m_lo; n = 0;
    sa = $signed(av); sb = $signed(bv);
    ua = av; ub = bv;
    case (op)
      3'd1: begin sp = sa * sb; eh = sp[63:32]; el = sp[31:0]; n = MC; end
      3'd2: begin up = ua * ub; eh = up[63:32]; el = up[31:0]; n = MC; end
      3'd3: begin
        n = DC;
        if (bv != 0) begin sq = sa / sb; sr = sa % sb; el = sq[31:0]; eh = sr[31:0]; end
      end
      3'd4: begin
        n = DC;
        if (bv != 0) begin el = av / bv; eh = av % bv; end
      end
      3'd5: eh = av;
      3'd6: el = av;
      default: ;
    endcase
    start = 1'b1; md_op = op; a = av; b = bv;
    @(negedge clk);
    start = 1'b0; md_op = 3'd0;
    for (int i = 0; i < n; i++) begin
      chk("busy_run", {31'd0, busy}, 32'd1);
      chk("hi_hold", hi, m_hi);
      chk("lo_hold", lo, m_lo);
      if ((noise == 1 && $urandom_range(0, 2) == 0) || (noise == 2 && (i == 2 || i == 3))) begin
        start = 1'b1;
        md_op = (noise == 2) ? ((i == 2) ? 3'd6 : 3'd1) : 3'($urandom_range(1, 6));
        a = (noise == 2) ? 32'hDEADBEEF : $urandom;
        b = $urandom;
      end
      @(negedge clk);
      start = 1'b0; md_op = 3'd0;
    end
    chk("busy_done", {31'd0, busy}, 32'd0);
    chk("hi_result", hi, eh);
    chk("lo_result", lo, el);
    m_hi = eh; m_lo = el;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; md_op = 3'd0; a = 32'd0; b = 32'd0;
    m_hi = 32'd0; m_lo = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);

    do_cmd(3'd1, 32'hFFFFFFFD, 32'd5, 0);
    chk("mult_neg3x5_hi", hi, 32'hFFFFFFFF);
    chk("mult_neg3x5_lo", lo, 32'hFFFFFFF1);
    do_cmd(3'd2, 32'hFFFFFFFF, 32'd2, 0);
    chk("multu_hi", hi, 32'h00000001);
    chk("multu_lo", lo, 32'hFFFFFFFE);
    do_cmd(3'd1, 32'hFFFFFFFF, 32'd2, 0);
    chk("mult_m1x2_hi", hi, 32'hFFFFFFFF);
    chk("mult_m1x2_lo", lo, 32'hFFFFFFFE);
    do_cmd(3'd3, 32'hFFFFFFF9, 32'd2, 0);
    chk("div_neg7_lo", lo, 32'hFFFFFFFD);
    chk("div_neg7_hi", hi, 32'hFFFFFFFF);
    do_cmd(3'd4, 32'd7, 32'd2, 0);
    chk("divu_7_2_lo", lo, 32'd3);
    chk("divu_7_2_hi", hi, 32'd1);
    do_cmd(3'd3, 32'h80000000, 32'hFFFFFFFF, 0);
    chk("div_ovf_lo", lo, 32'h80000000);
    chk("div_ovf_hi", hi, 32'h00000000);
    do_cmd(3'd5, 32'h12345678, 32'd0, 0);
    chk("mthi_hi", hi, 32'h12345678);
    do_cmd(3'd4, 32'd9, 32'd0, 0);
    chk("divu_by0_hi", hi, 32'h12345678);
    do_cmd(3'd0, 32'h5555AAAA, 32'd1, 0);
    do_cmd(3'd7, 32'h5555AAAA, 32'd1, 0);
    do_cmd(3'd3, 32'd100, 32'd7, 2);
    chk("div_noise_lo", lo, 32'd14);
    do_cmd(3'd1, 32'd6, 32'd7, 0);
    chk("b2b_mult_lo", lo, 32'd42);

    // Reset mid-mult: the pending product must never land.
    do_cmd(3'd6, 32'h000000AA, 32'd0, 0);
    start = 1'b1; md_op = 3'd1; a = 32'd7; b = 32'd9;
    @(negedge clk);
    start = 1'b0; md_op = 3'd0;
    chk("rst_mid_busy_pre", {31'd0, busy}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    chk("rst_mid_hi", hi, 32'd0);
    for (int i = 0; i < MC + 2; i++) begin
      @(negedge clk);
      chk("rst_no_late_lo", lo, 32'd0);
      chk("rst_no_late_busy", {31'd0, busy}, 32'd0);
    end

    for (int k = 0; k < 80; k++) begin
      logic [2:0]  op;
      logic [31:0] av, bv;
      op = 3'($urandom_range(0, 7));
      av = $urandom; bv = $urandom;
      case ($urandom_range(0, 7))
        0: bv = 32'd0;
        1: begin av = 32'h80000000; bv = 32'hFFFFFFFF; end
        2: bv = 32'($urandom_range(1, 9));
        default: ;
      endcase
      do_cmd(op, av, bv, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
